// File: rtl/dijkstra_result_writer_pkg.sv
// Shared constants for the Dijkstra engine: default widths, sentinel values
// and the layout of the result region written back to memory.
package dijkstra_result_writer_pkg;

    // Default sizing of the engine's result vectors and memory port.
    localparam int DEFAULT_MAX_NODES   = 8;
    localparam int DEFAULT_INDEX_WIDTH = 4;
    localparam int DEFAULT_VALUE_WIDTH = 16;
    localparam int DEFAULT_MADDR_WIDTH = 16;
    localparam int DEFAULT_MDATA_WIDTH = 32;

    // Sentinels produced by the search core; written back verbatim.
    localparam logic [DEFAULT_INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = '1;
    localparam logic [DEFAULT_VALUE_WIDTH-1:0] UNVISITED        = '1;

    // Number of words preceding the per-node entries in the result region.
    localparam int RESULT_HEADER_WORDS = 1;

endpackage

// File: rtl/dijkstra_result_writer.sv
// Drains the search core's predecessor and distance vectors into memory:
// one header word holding the node count, then one packed word per node.
// Both vectors are snapshotted on start so the core may move on at once.
module dijkstra_result_writer
    import dijkstra_result_writer_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [INDEX_WIDTH-1:0]           number_of_nodes,
    input  logic [MADDR_WIDTH-1:0]           base_address,
    input  logic [MAX_NODES*INDEX_WIDTH-1:0] prev_vector_flat,
    input  logic [MAX_NODES*VALUE_WIDTH-1:0] distance_vector_flat,
    output logic                             busy,
    output logic                             done,
    output logic                             mem_write_enable,
    input  logic                             mem_write_ready,
    output logic [MADDR_WIDTH-1:0]           mem_addr,
    output logic [MDATA_WIDTH-1:0]           mem_write_data
);

    // An entry word must hold a predecessor and a distance side by side.
    if (INDEX_WIDTH + VALUE_WIDTH > MDATA_WIDTH) begin : g_width_check
        $error("dijkstra_result_writer: INDEX_WIDTH+VALUE_WIDTH exceeds MDATA_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        ENTRY,
        DONE
    } state_t;

    state_t state, state_next;

    // Snapshot of the job taken on the accepted start.
    logic [MAX_NODES*INDEX_WIDTH-1:0] prev_q;
    logic [MAX_NODES*VALUE_WIDTH-1:0] dist_q;
    logic [INDEX_WIDTH-1:0]           count_q;
    logic [MADDR_WIDTH-1:0]           base_q;

    // Entry counter and its next value.
    logic [INDEX_WIDTH-1:0] k_q, k_next;

    // Next values of the registered outputs.
    logic                   busy_next;
    logic                   done_next;
    logic                   enable_next;
    logic [MADDR_WIDTH-1:0] addr_next;
    logic [MDATA_WIDTH-1:0] data_next;

    logic                   start_accept;
    logic                   handshake;
    logic [INDEX_WIDTH-1:0] clamped_count;

    assign start_accept = (state == IDLE) && start;
    assign handshake    = mem_write_enable && mem_write_ready;

    // Limit the requested node count to the capacity of the result vectors.
    always_comb begin
        // NOTE: every signal driven from always_comb gets a default first so no path infers a latch.
        clamped_count = number_of_nodes;
        if (32'(number_of_nodes) > 32'(MAX_NODES)) begin
            clamped_count = INDEX_WIDTH'(MAX_NODES);
        end
    end

    // Next state, entry counter and next output values; outputs hold unless a handshake or start moves them.
    always_comb begin
        state_next  = state;
        k_next      = k_q;
        busy_next   = busy;
        done_next   = 1'b0;
        enable_next = mem_write_enable;
        addr_next   = mem_addr;
        data_next   = mem_write_data;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = HEADER;
                    k_next      = '0;
                    busy_next   = 1'b1;
                    enable_next = 1'b1;
                    addr_next   = base_address;
                    data_next   = MDATA_WIDTH'(clamped_count);
                end
            end

            HEADER: begin
                if (handshake) begin
                    if (count_q == '0) begin
                        state_next  = DONE;
                        busy_next   = 1'b0;
                        done_next   = 1'b1;
                        enable_next = 1'b0;
                        addr_next   = '0;
                        data_next   = '0;
                    end else begin
                        state_next = ENTRY;
                        k_next     = '0;
                        addr_next  = base_q + MADDR_WIDTH'(RESULT_HEADER_WORDS);
                        data_next  = MDATA_WIDTH'({dist_q[0 +: VALUE_WIDTH],
                                                   prev_q[0 +: INDEX_WIDTH]});
                    end
                end
            end

            ENTRY: begin
                if (handshake) begin
                    if (k_q == count_q - INDEX_WIDTH'(1)) begin
                        state_next  = DONE;
                        busy_next   = 1'b0;
                        done_next   = 1'b1;
                        enable_next = 1'b0;
                        addr_next   = '0;
                        data_next   = '0;
                    end else begin
                        k_next    = k_q + INDEX_WIDTH'(1);
                        addr_next = base_q + MADDR_WIDTH'(RESULT_HEADER_WORDS)
                                  + MADDR_WIDTH'(k_next);
                        data_next = MDATA_WIDTH'({dist_q[k_next*VALUE_WIDTH +: VALUE_WIDTH],
                                                  prev_q[k_next*INDEX_WIDTH +: INDEX_WIDTH]});
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next  = IDLE;
                busy_next   = 1'b0;
                enable_next = 1'b0;
                addr_next   = '0;
                data_next   = '0;
            end
        endcase
    end

    // State, counter and registered outputs, with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state            <= IDLE;
            k_q              <= '0;
            count_q          <= '0;
            base_q           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
        end else begin
            state            <= state_next;
            k_q              <= k_next;
            busy             <= busy_next;
            done             <= done_next;
            mem_write_enable <= enable_next;
            mem_addr         <= addr_next;
            mem_write_data   <= data_next;
            if (start_accept) begin
                count_q <= clamped_count;
                base_q  <= base_address;
            end
        end
    end

    // Capture both result vectors when a dump is accepted.
    always_ff @(posedge clock) begin
        // NOTE: the vector snapshot has no reset; it is always overwritten on start before any entry is read.
        if (start_accept) begin
            prev_q <= prev_vector_flat;
            dist_q <= distance_vector_flat;
        end
    end

endmodule

// File: doc/dijkstra_result_writer.md
# dijkstra_result_writer

Write-side counterpart to the edge-fetch path of the Dijkstra engine: once the search core finishes, it drains the per-node predecessor and distance results into system memory over the shared valid/ready memory interface. It snapshots both result vectors on `start`, then emits one header word followed by one packed word per node. It sits beside the edge cache on the memory port. The edge cache owns the read side of that port; this block owns the write side.

## Interface
- `MAX_NODES`, default `DEFAULT_MAX_NODES`: capacity of the result vectors.
- `INDEX_WIDTH`, default `DEFAULT_INDEX_WIDTH`: width of a node index / predecessor.
- `VALUE_WIDTH`, default `DEFAULT_VALUE_WIDTH`: width of a distance.
- `MADDR_WIDTH`, default `DEFAULT_MADDR_WIDTH`: memory address width.
- `MDATA_WIDTH`, default `DEFAULT_MDATA_WIDTH`: memory data width. Must satisfy INDEX_WIDTH+VALUE_WIDTH <= MDATA_WIDTH; elaboration error otherwise.
- `clock`  in  1  clock; all logic on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to dump results; ignored unless idle.
- `number_of_nodes`  in  INDEX_WIDTH  nodes to write; sampled on accepted `start`.
- `base_address`  in  MADDR_WIDTH  result region base; sampled on accepted `start`.
- `prev_vector_flat`  in  MAX_NODES*INDEX_WIDTH  predecessor of node i at bits [i*INDEX_WIDTH +: INDEX_WIDTH].
- `distance_vector_flat`  in  MAX_NODES*VALUE_WIDTH  distance of node i at bits [i*VALUE_WIDTH +: VALUE_WIDTH].
- `busy`  out  1  high from the cycle after accepted `start` until the cycle after the last write handshake.
- `done`  out  1  one-cycle pulse when the dump completes.
- `mem_write_enable`  out  1  write request valid.
- `mem_write_ready`  in  1  memory accepts the write this cycle.
- `mem_addr`  out  MADDR_WIDTH  write address.
- `mem_write_data`  out  MDATA_WIDTH  write data.

## Operation
- States: IDLE, HEADER, ENTRY, DONE.
- IDLE: `start`=1 latches the count, base, and both vectors into internal registers, clears the entry counter k, and moves to HEADER. Later input changes have no effect on the dump in progress.
- Count clamp: a latched count greater than MAX_NODES is clamped to MAX_NODES.
- HEADER: `mem_write_enable`=1, `mem_addr`=base, `mem_write_data`=clamped count, zero-extended.
  - On handshake with count 0: go to DONE.
  - On handshake otherwise: go to ENTRY.
- ENTRY: `mem_write_enable`=1, `mem_addr`=base+1+k, `mem_write_data`={zeros, distance[k], prev[k]}, with prev in the LSBs.
  - On handshake: k increments.
  - On the handshake with k = count-1: go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then return to IDLE. A `start` asserted during DONE is ignored.
- Handshake: a write transfers on any cycle with `mem_write_enable` && `mem_write_ready`.
  - While enable is high and ready is low, address and data hold stable.
  - Enable never drops before its handshake.
- Address arithmetic is modulo 2^MADDR_WIDTH; wrap past all-ones is legal and silent.
- Sentinel values (`NO_PREVIOUS_NODE`, all-ones distance) are written verbatim; no filtering.
- `mem_write_enable` is driven only by this block. The block never drives read signals.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_write_enable`=0, `mem_addr`=0, `mem_write_data`=0; state IDLE, k=0.
- Reset asserted mid-dump:
  - All outputs return to reset values at that edge.
  - No `done` pulse.
  - The partial write is abandoned.
- Accepted `start` at edge 0:
  - `busy`=1 and HEADER request visible after edge 0.
  - With `mem_write_ready` tied high: N+1 writes occupy N+1 consecutive cycles, and `done` is high in the following cycle (cycle N+2).
- Each cycle of `mem_write_ready`=0 adds exactly one cycle of latency.
- All outputs are registered; there is no combinational path from `mem_write_ready` to any output.

## Structure
- Shared constants package (existing): `DEFAULT_*` widths, `NO_PREVIOUS_NODE`, `UNVISITED`. Add `RESULT_HEADER_WORDS` (=1) there.
- State enum is local to this module.
- Single module, no sub-module needed. Vector snapshot registers and the output holding register live in the same file.

## Test plan
- Reset, then idle 5 cycles → all outputs 0; no write issued.
- N=3, base=0x100, ready high, prev={2,0,NO_PREVIOUS_NODE}, dist={7,0,all-ones} → writes 0x100←3, 0x101←{7,2}, 0x102←{0,0}, 0x103←{all-ones,NO_PREV}; `done` in cycle 5.
- Same stimulus with ready low for 2 cycles on entry 1 → address and data held stable; 0x102 written exactly once; `done` delayed 2 cycles.
- N=0 → single header write 0x100←0, `done` next cycle. N=MAX_NODES+4 → header holds MAX_NODES and exactly MAX_NODES entries follow.
- Base=all-ones, N=2 → addresses all-ones, 0, 1. A second `start` pulsed mid-dump is ignored, and the inputs changed mid-dump do not alter the data written.
- Reset asserted during entry 1 → enable 0 at the next edge, no `done`; a fresh `start` afterwards completes normally.
